// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NR_CH stream demultiplexer.
// Each accepted word is steered by in_sel into a one-entry output register
// for that channel. Words whose in_sel names no channel are accepted and
// dropped, with a one-cycle sel_err pulse.
//
// Handshake (input and every output channel): a word moves on the rising
// edge where valid && ready are both 1. A source holds its word stable
// while valid=1 and ready=0. Valid never depends on ready of the same port.
//
// Optional build macro DEMUX_DROP_CNT_EN adds the CNT_W parameter and a
// saturating drop_cnt output that counts dropped (out-of-range) words.
//
// Channel state is the EMPTY/FULL bit out_valid[i]; it is already an
// output, so no separate debug port is needed to observe it.
module stream_demux #(
    parameter int NR_CH  = 4,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 2
`ifdef DEMUX_DROP_CNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NR_CH-1:0]        out_valid,
    input  logic [NR_CH-1:0]        out_ready,
    output logic [NR_CH*DATA_W-1:0] out_data,
    output logic                    sel_err
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]        drop_cnt
`endif
);

    logic [NR_CH-1:0]        valid_q, valid_d;
    logic [NR_CH*DATA_W-1:0] data_q, data_d;
    logic                    sel_err_q, sel_err_d;
    logic                    in_range;
    logic                    dst_ready;
    logic                    accept;
    logic [NR_CH-1:0]        load;
    logic [NR_CH-1:0]        drain;

    // Decode in_sel: is it a real channel, and can that channel take a word.
    // Out-of-range words are always sunk; nothing is ready while in reset.
    always_comb begin
        in_range  = 1'b0;
        dst_ready = 1'b0;
        for (int i = 0; i < NR_CH; i++) begin
            if (in_sel == SEL_W'(i)) begin
                in_range  = 1'b1;
                dst_ready = !valid_q[i] || out_ready[i];
            end
        end
        in_ready = rst_n && (in_range ? dst_ready : 1'b1);
        accept   = in_valid && in_ready;
    end

    // Per-channel register update: load wins over drain so a full channel
    // that drains and reloads in one cycle stays valid (no bubble).
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        load    = '0;
        drain   = '0;
        for (int i = 0; i < NR_CH; i++) begin
            drain[i] = valid_q[i] && out_ready[i];
            load[i]  = accept && in_range && (in_sel == SEL_W'(i));
            if (load[i]) begin
                valid_d[i]                   = 1'b1;
                data_d[i*DATA_W +: DATA_W]   = in_data;
            end else if (drain[i]) begin
                valid_d[i]                   = 1'b0;
            end
        end
        sel_err_d = accept && !in_range;
    end

    // Channel registers and the drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            data_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel_err   = sel_err_q;

`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped words; only reset clears it.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (sel_err_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Without the drop counter, dropped words are visible only via sel_err.
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux. Two instances share one stimulus stream:
// u_dut4 (NR_CH=4, every sel in range) and u_dut3 (NR_CH=3, sel=3 drops).
// A per-channel expected-data queue is filled when a word is accepted and
// drained when the channel handshakes.
module tb_stream_demux;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_sel;
    logic [1:0] in_data;
    logic [3:0] out_ready;

    logic       in_ready4;
    logic [3:0] out_valid4;
    logic [7:0] out_data4;
    logic       sel_err4;

    logic       in_ready3;
    logic [2:0] out_valid3;
    logic [5:0] out_data3;
    logic       sel_err3;

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt4;
    logic [7:0] drop_cnt3;
`endif

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_demux #(
        .NR_CH(4), .SEL_W(2), .DATA_W(2)
`ifdef DEMUX_DROP_CNT_EN
        , .CNT_W(8)
`endif
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .sel_err(sel_err4)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt4)
`endif
    );

    stream_demux #(
        .NR_CH(3), .SEL_W(2), .DATA_W(2)
`ifdef DEMUX_DROP_CNT_EN
        , .CNT_W(8)
`endif
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready3),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid3), .out_ready(out_ready[2:0]),
        .out_data(out_data3), .sel_err(sel_err3)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_cnt(drop_cnt3)
`endif
    );

    // scoreboard: queue index = id*4 + channel (id 0 = dut4, id 1 = dut3)
    logic [1:0] exp_q [8][$];
    logic       exp_err [2];
    int         exp_drop [2];
    logic       last_ir [2];
    int         n_checks;
    int         n_pass;
    int         n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        for (int id = 0; id < 2; id++) begin
            exp_err[id]  = 1'b0;
            exp_drop[id] = 0;
        end
    endtask

    // Registered state seen between edges: valid bits, held data, sel_err.
    task automatic check_state(input int id, input int nch, input logic [3:0] ov,
                               input logic [7:0] od, input logic se);
        for (int ch = 0; ch < nch; ch++) begin
            chk($sformatf("valid d%0d ch%0d", id, ch), 32'(ov[ch]),
                32'(exp_q[id*4+ch].size() != 0));
            if (exp_q[id*4+ch].size() != 0)
                chk($sformatf("held d%0d ch%0d", id, ch), 32'(od[ch*2 +: 2]),
                    32'(exp_q[id*4+ch][0]));
        end
        chk($sformatf("sel_err d%0d", id), 32'(se), 32'(exp_err[id]));
    endtask

    // Inputs are driven: check in_ready, pop drained words, push accepted one.
    task automatic handshake(input int id, input int nch, input logic ir,
                             input logic [7:0] od);
        logic exp_ir;
        logic in_rng;
        logic acc;
        in_rng = (int'(in_sel) < nch);
        exp_ir = in_rng ? (exp_q[id*4+int'(in_sel)].size() == 0 || out_ready[in_sel]) : 1'b1;
        chk($sformatf("in_ready d%0d sel%0d", id, in_sel), 32'(ir), 32'(exp_ir));
        last_ir[id] = exp_ir;
        for (int ch = 0; ch < nch; ch++) begin
            if (exp_q[id*4+ch].size() != 0 && out_ready[ch]) begin
                chk($sformatf("drain d%0d ch%0d", id, ch), 32'(od[ch*2 +: 2]),
                    32'(exp_q[id*4+ch][0]));
                void'(exp_q[id*4+ch].pop_front());
            end
        end
        acc = in_valid && exp_ir;
        if (acc && in_rng) exp_q[id*4+int'(in_sel)].push_back(in_data);
        exp_err[id] = acc && !in_rng;
        if (acc && !in_rng && exp_drop[id] < 255) exp_drop[id]++;
    endtask

    // driver: one clock step with checks before and after driving inputs
    task automatic step(input logic v, input logic [1:0] s, input logic [1:0] d,
                        input logic [3:0] r);
        @(negedge clk);
        check_state(0, 4, out_valid4, out_data4, sel_err4);
        check_state(1, 3, {1'b0, out_valid3}, {2'b00, out_data3}, sel_err3);
`ifdef DEMUX_DROP_CNT_EN
        chk("drop_cnt d0", 32'(drop_cnt4), 32'(exp_drop[0]));
        chk("drop_cnt d1", 32'(drop_cnt3), 32'(exp_drop[1]));
`endif
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        handshake(0, 4, in_ready4, out_data4);
        handshake(1, 3, in_ready3, {2'b00, out_data3});
    endtask

    initial begin
        logic       hold;
        logic       rv;
        logic [1:0] rs;
        logic [1:0] rd;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        clear_model();
        last_ir[0] = 1'b0;
        last_ir[1] = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 2'd0;
        out_ready = 4'h0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst out_valid d0", 32'(out_valid4), 32'h0);
        chk("rst out_data d0", 32'(out_data4), 32'h0);
        chk("rst sel_err d0", 32'(sel_err4), 32'h0);
        chk("rst in_ready d0", 32'(in_ready4), 32'h0);
        chk("rst out_valid d1", 32'(out_valid3), 32'h0);
        chk("rst in_ready d1", 32'(in_ready3), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
        chk("rst drop_cnt d1", 32'(drop_cnt3), 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        chk("release in_ready d0", 32'(in_ready4), 32'h1);
        in_valid = 1'b0;

        // load ch2, then a stalled retry (ch2 full, not ready)
        step(1'b1, 2'd2, 2'b11, 4'b0000);
        step(1'b1, 2'd2, 2'b01, 4'b0000);
        // drain and reload ch2 in the same cycle
        step(1'b1, 2'd2, 2'b01, 4'b0100);
        // back-to-back over all channels, consumers always ready
        step(1'b1, 2'd0, 2'b00, 4'b1111);
        step(1'b1, 2'd1, 2'b01, 4'b1111);
        step(1'b1, 2'd2, 2'b10, 4'b1111);
        step(1'b1, 2'd3, 2'b11, 4'b1111);
        step(1'b0, 2'd0, 2'b00, 4'b1111);
        // out-of-range on dut3 with nothing pending
        step(1'b1, 2'd3, 2'b10, 4'b0000);
        step(1'b0, 2'd0, 2'b00, 4'b0000);
        step(1'b0, 2'd0, 2'b00, 4'b1111);
        // ch1 stuck full while ch3 drains
        step(1'b1, 2'd1, 2'b01, 4'b0000);
        step(1'b1, 2'd3, 2'b11, 4'b0000);
        step(1'b1, 2'd1, 2'b10, 4'b1000);
        step(1'b1, 2'd1, 2'b10, 4'b1000);
        step(1'b1, 2'd1, 2'b10, 4'b0010);
        step(1'b0, 2'd0, 2'b00, 4'b1111);

        // random traffic; a stalled word is held until both instances take it
        hold = 1'b0;
        rv = 1'b0;
        rs = 2'd0;
        rd = 2'd0;
        for (int k = 0; k < 80; k++) begin
            if (!hold) begin
                rv = 1'($urandom_range(0, 1));
                rs = 2'($urandom_range(0, 3));
                rd = 2'($urandom_range(0, 3));
            end
            step(rv, rs, rd, 4'($urandom_range(0, 15)));
            hold = rv && !(last_ir[0] && last_ir[1]);
        end
        // a held word may still be pending: offer it with all consumers ready
        if (hold) step(rv, rs, rd, 4'b1111);
        step(1'b0, 2'd0, 2'b00, 4'b1111);
        step(1'b0, 2'd0, 2'b00, 4'b1111);

`ifdef DEMUX_DROP_CNT_EN
        // drop counter saturation on dut3
        for (int k = 0; k < 300; k++) step(1'b1, 2'd3, 2'b10, 4'b1111);
        step(1'b0, 2'd0, 2'b00, 4'b1111);
        chk("drop_cnt saturated d1", 32'(drop_cnt3), 32'd255);
`endif

        // reset mid-stream with ch0 and ch2 full
        step(1'b1, 2'd0, 2'b01, 4'b0000);
        step(1'b1, 2'd2, 2'b10, 4'b0000);
        step(1'b0, 2'd0, 2'b00, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid d0", 32'(out_valid4), 32'h0);
        chk("midrst out_data d0", 32'(out_data4), 32'h0);
        chk("midrst out_valid d1", 32'(out_valid3), 32'h0);
        chk("midrst out_data d1", 32'(out_data3), 32'h0);
        chk("midrst in_ready d0", 32'(in_ready4), 32'h0);
        clear_model();
        in_valid = 1'b1;
        in_sel   = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("inrst in_ready d0", 32'(in_ready4), 32'h0);
        chk("inrst in_ready d1", 32'(in_ready3), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready d0", 32'(in_ready4), 32'h1);
        chk("post-rst in_ready d1", 32'(in_ready3), 32'h1);
        in_valid = 1'b0;
        step(1'b1, 2'd0, 2'b11, 4'b0000);
        step(1'b0, 2'd0, 2'b00, 4'b1111);
        step(1'b0, 2'd0, 2'b00, 4'b0000);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
